branch_commit_update: RTL and testbench

Commit-side producer for the branch predictor's update bus. Sits between the ROB commit port and the BTB/perceptron predictor. Captures every committed conditional branch and JAL, buffers them in a small FIFO, and replays them to the predictor one per cycle as single-cycle update pulses. Holds off for the predictor's `btb_busy` and keeps saturating branch and mispredict performance counters.

---
 rtl/branch_commit_update_if.sv | 37 +++
 rtl/branch_commit_update.sv | 104 ++++++++++
 tb/tb_branch_commit_update.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_commit_update_if.sv
// Commit-to-predictor update bus: ROB commit port, stall back-pressure,
// predictor busy and the registered update pulse with its payload.
interface branch_commit_update_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_is_branch;
  logic        commit_is_jal;
  logic        commit_taken;
  logic        commit_pred_taken;
  logic [31:0] commit_target;
  logic        commit_stall;
  logic        btb_busy;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_branch;
  logic        upd_jal;
  logic        upd_resol;
  logic        upd_ghr_bit;

  // Environment side: ROB commit port and branch predictor.
  modport master (
    output commit_valid, commit_pc, commit_is_branch, commit_is_jal,
           commit_taken, commit_pred_taken, commit_target, btb_busy,
    input  commit_stall, upd_valid, upd_ready, upd_pc, upd_target,
           upd_branch, upd_jal, upd_resol, upd_ghr_bit
  );

  // Update producer side.
  modport slave (
    input  commit_valid, commit_pc, commit_is_branch, commit_is_jal,
           commit_taken, commit_pred_taken, commit_target, btb_busy,
    output commit_stall, upd_valid, upd_ready, upd_pc, upd_target,
           upd_branch, upd_jal, upd_resol, upd_ghr_bit
  );
endinterface

// File: rtl/branch_commit_update.sv
// Buffers committed branches/JALs in commit order and replays them to the
// branch predictor as one-cycle update pulses; keeps saturating perf counters.
module branch_commit_update #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_commit_update_if.slave bus,
  output logic [CNT_W-1:0]     perf_branches,
  output logic [CNT_W-1:0]     perf_mispred
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        branch;
    logic        jal;
    logic        taken;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  entry_t        out_q;
  logic          out_valid;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          count_branch;
  logic          mispred;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    push         = bus.commit_valid && (bus.commit_is_branch || bus.commit_is_jal) && !full;
    pop          = !bus.btb_busy && !empty;
    count_branch = push && bus.commit_is_branch;
    mispred      = bus.commit_taken != bus.commit_pred_taken;

    // A commit flagged as both branch and JAL is replayed as a branch.
    wr_entry.pc     = bus.commit_pc;
    wr_entry.target = bus.commit_target;
    wr_entry.branch = bus.commit_is_branch;
    wr_entry.jal    = bus.commit_is_jal && !bus.commit_is_branch;
    wr_entry.taken  = bus.commit_taken;

    head = mem[rd_ptr[AW-1:0]];
  end

  // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload holds its last value between pulses; the valid flag is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      out_valid <= pop;
      if (pop) out_q <= head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (count_branch) begin
      if (perf_branches != '1)           perf_branches <= perf_branches + CNT_W'(1);
      if (mispred && perf_mispred != '1) perf_mispred  <= perf_mispred + CNT_W'(1);
    end
  end

  assign bus.commit_stall = full;
  assign bus.upd_valid    = out_valid;
  assign bus.upd_ready    = out_valid;
  assign bus.upd_pc       = out_q.pc;
  assign bus.upd_target   = out_q.target;
  assign bus.upd_branch   = out_q.branch;
  assign bus.upd_jal      = out_q.jal;
  assign bus.upd_resol    = out_q.taken;
  assign bus.upd_ghr_bit  = out_q.taken;

endmodule

// File: tb/tb_branch_commit_update.sv
// Directed bench: main instance (DEPTH=4, CNT_W=32) plus a CNT_W=4 instance
// used to drive the performance counters into saturation.
module tb_branch_commit_update;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;
  logic [3:0]  s_perf_branches;
  logic [3:0]  s_perf_mispred;
  int          checks = 0;
  int          errors = 0;
  int          pulses;
  logic [31:0] exp_pc_q[$];
  logic        exp_resol_q[$];

  branch_commit_update_if bus ();
  branch_commit_update_if sbus ();

  branch_commit_update #(.DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  branch_commit_update #(.DEPTH(4), .CNT_W(4)) sdut (
    .clk(clk), .rst(rst), .bus(sbus),
    .perf_branches(s_perf_branches), .perf_mispred(s_perf_mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                       input logic jal, input logic tk, input logic pr);
    bus.commit_valid      = 1'b1;
    bus.commit_pc         = pc;
    bus.commit_target     = tgt;
    bus.commit_is_branch  = br;
    bus.commit_is_jal     = jal;
    bus.commit_taken      = tk;
    bus.commit_pred_taken = pr;
  endtask

  task automatic idle();
    bus.commit_valid      = 1'b0;
    bus.commit_pc         = '0;
    bus.commit_target     = '0;
    bus.commit_is_branch  = 1'b0;
    bus.commit_is_jal     = 1'b0;
    bus.commit_taken      = 1'b0;
    bus.commit_pred_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.btb_busy           = 1'b0;
    sbus.commit_valid      = 1'b0;
    sbus.commit_pc         = '0;
    sbus.commit_target     = '0;
    sbus.commit_is_branch  = 1'b0;
    sbus.commit_is_jal     = 1'b0;
    sbus.commit_taken      = 1'b0;
    sbus.commit_pred_taken = 1'b0;
    sbus.btb_busy          = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_valid",  bus.upd_valid, 0);
    check("rst_ready",  bus.upd_ready, 0);
    check("rst_pc",     bus.upd_pc, 0);
    check("rst_target", bus.upd_target, 0);
    check("rst_flags",  {bus.upd_branch, bus.upd_jal, bus.upd_resol, bus.upd_ghr_bit}, 0);
    check("rst_stall",  bus.commit_stall, 0);
    check("rst_perf_b", perf_branches, 0);
    check("rst_perf_m", perf_mispred, 0);
    check("rst_sperf",  {s_perf_branches, s_perf_mispred}, 0);
    rst = 1'b1;

    // Single branch: pulse one cycle after the commit edge
    drive(32'h100, 32'h180, 1, 0, 1, 0);
    cyc();
    idle();
    check("single_no_early_pulse", bus.upd_valid, 0);
    check("single_perf_b", perf_branches, 1);
    check("single_perf_m", perf_mispred, 1);
    cyc();
    check("single_valid",  bus.upd_valid, 1);
    check("single_ready",  bus.upd_ready, 1);
    check("single_pc",     bus.upd_pc, 32'h100);
    check("single_target", bus.upd_target, 32'h180);
    check("single_flags",  {bus.upd_branch, bus.upd_jal, bus.upd_resol, bus.upd_ghr_bit}, 4'b1011);
    cyc();
    check("single_pulse_end", bus.upd_valid, 0);
    check("single_hold_pc",   bus.upd_pc, 32'h100);
    cyc();
    check("single_no_repeat", bus.upd_valid, 0);

    // Fill and stall with the predictor busy
    bus.btb_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 1, 0, i[0], 0);
      cyc();
      check("fill_stall", bus.commit_stall, (i == 3) ? 1 : 0);
      check("fill_no_pulse", bus.upd_valid, 0);
    end
    drive(32'h1010, 32'h2010, 1, 0, 0, 0);
    cyc();
    check("full_stall_held", bus.commit_stall, 1);
    check("full_drop_perf_b", perf_branches, 5);
    check("full_drop_perf_m", perf_mispred, 3);
    bus.btb_busy = 1'b0;
    cyc();
    check("drain0_valid", bus.upd_valid, 1);
    check("drain0_pc",    bus.upd_pc, 32'h1000);
    check("drain0_resol", bus.upd_resol, 0);
    check("drain0_stall", bus.commit_stall, 0);
    cyc();
    idle();
    check("drain1_valid",  bus.upd_valid, 1);
    check("drain1_pc",     bus.upd_pc, 32'h1004);
    check("drain1_resol",  bus.upd_resol, 1);
    check("fifth_perf_b",  perf_branches, 6);
    cyc();
    check("drain2_pc", {bus.upd_valid, bus.upd_pc}, {1'b1, 32'h1008});
    cyc();
    check("drain3_pc", {bus.upd_valid, bus.upd_pc}, {1'b1, 32'h100c});
    cyc();
    check("fifth_pc",     {bus.upd_valid, bus.upd_pc}, {1'b1, 32'h1010});
    check("fifth_target", bus.upd_target, 32'h2010);
    cyc();
    check("drain_done",   bus.upd_valid, 0);
    check("drain_perf_m", perf_mispred, 3);

    // Mixed traffic: ALU, JAL, ALU, branch
    drive(32'h300, 32'h0, 0, 0, 0, 0);
    cyc();
    check("mix_alu_ignored", bus.upd_valid, 0);
    drive(32'h200, 32'h240, 0, 1, 1, 0);
    cyc();
    check("mix_jal_latency", bus.upd_valid, 0);
    drive(32'h304, 32'h0, 0, 0, 0, 0);
    cyc();
    check("mix_jal_valid",  bus.upd_valid, 1);
    check("mix_jal_pc",     bus.upd_pc, 32'h200);
    check("mix_jal_target", bus.upd_target, 32'h240);
    check("mix_jal_flags",  {bus.upd_branch, bus.upd_jal, bus.upd_resol, bus.upd_ghr_bit}, 4'b0111);
    drive(32'h210, 32'h260, 1, 0, 0, 0);
    cyc();
    check("mix_alu2_ignored", bus.upd_valid, 0);
    idle();
    cyc();
    check("mix_br_valid", bus.upd_valid, 1);
    check("mix_br_pc",    bus.upd_pc, 32'h210);
    check("mix_br_flags", {bus.upd_branch, bus.upd_jal, bus.upd_resol, bus.upd_ghr_bit}, 4'b1000);
    check("mix_perf_b",   perf_branches, 7);
    check("mix_perf_m",   perf_mispred, 3);
    drive(32'h220, 32'h280, 1, 1, 1, 1);
    cyc();
    idle();
    cyc();
    check("both_pc",     bus.upd_pc, 32'h220);
    check("both_flags",  {bus.upd_valid, bus.upd_branch, bus.upd_jal}, 3'b110);
    check("both_perf_b", perf_branches, 8);

    // Concurrent push and pop
    for (int i = 0; i < 6; i++) begin
      drive(32'h400 + 32'(i * 4), 32'h480, 1, 0, 1, 1);
      cyc();
      check("stream_stall", bus.commit_stall, 0);
      if (i > 0) check("stream_pulse", {bus.upd_valid, bus.upd_pc}, {1'b1, 32'h400 + 32'((i - 1) * 4)});
    end
    idle();
    cyc();
    check("stream_last", {bus.upd_valid, bus.upd_pc}, {1'b1, 32'h414});
    cyc();
    check("stream_end",    bus.upd_valid, 0);
    check("stream_perf_b", perf_branches, 14);
    check("stream_perf_m", perf_mispred, 3);

    // Pointer wrap: 3*DEPTH+1 commits with a short busy window
    pulses = 0;
    for (int i = 0; i < 21; i++) begin
      if (i < 13) begin
        drive(32'h500 + 32'(i * 4), 32'h600, 1, 0, i[0], 0);
        exp_pc_q.push_back(32'h500 + 32'(i * 4));
        exp_resol_q.push_back(i[0]);
      end else begin
        idle();
      end
      bus.btb_busy = (i < 3);
      cyc();
      if (bus.upd_valid) begin
        pulses++;
        if (exp_pc_q.size() == 0) check("wrap_spurious", bus.upd_valid, 0);
        else begin
          check("wrap_pc",    bus.upd_pc, exp_pc_q.pop_front());
          check("wrap_resol", bus.upd_resol, exp_resol_q.pop_front());
        end
      end
    end
    check("wrap_pulses",  pulses, 13);
    check("wrap_drained", exp_pc_q.size(), 0);
    check("wrap_perf_b",  perf_branches, 27);
    check("wrap_perf_m",  perf_mispred, 9);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 17; i++) begin
      sbus.commit_valid      = 1'b1;
      sbus.commit_pc         = 32'h800 + 32'(i * 4);
      sbus.commit_target     = 32'h900;
      sbus.commit_is_branch  = 1'b1;
      sbus.commit_taken      = 1'b1;
      sbus.commit_pred_taken = 1'b0;
      cyc();
      if (i == 13) check("sat_mispred_14", s_perf_mispred, 4'd14);
    end
    sbus.commit_valid = 1'b0;
    check("sat_mispred", s_perf_mispred, 4'd15);
    check("sat_branches", s_perf_branches, 4'd15);
    repeat (6) cyc();

    // Async reset with three entries queued
    bus.btb_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h700 + 32'(i * 4), 32'h780, 1, 0, 1, 0);
      cyc();
    end
    idle();
    check("pre_rst_pc", bus.upd_pc, 32'h530);
    bus.btb_busy = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid",  bus.upd_valid, 0);
    check("arst_pc",     bus.upd_pc, 0);
    check("arst_target", bus.upd_target, 0);
    check("arst_flags",  {bus.upd_branch, bus.upd_jal, bus.upd_resol, bus.upd_ghr_bit}, 0);
    check("arst_stall",  bus.commit_stall, 0);
    check("arst_perf",   {perf_branches, perf_mispred}, 0);
    @(negedge clk);
    cyc();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.upd_valid) pulses++;
    end
    check("arst_no_pulse", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
